// File: rtl/seq_alu_if.sv
// Handshake and data bundle between the operand-stack read stage, the
// sequential ALU and stack write-back. The ALU uses the slave modport.
interface seq_alu_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       op_select;
   logic [WIDTH-1:0] operand_a;
   logic [WIDTH-1:0] operand_b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result_lo;
   logic [WIDTH-1:0] result_hi;
   logic             div_zero;
   logic             op_err;

   modport master (
      output in_valid, op_select, operand_a, operand_b, out_ready,
      input  in_ready, out_valid, result_lo, result_hi, div_zero, op_err
   );

   modport slave (
      input  in_valid, op_select, operand_a, operand_b, out_ready,
      output in_ready, out_valid, result_lo, result_hi, div_zero, op_err
   );
endinterface

// File: rtl/seq_alu.sv
// Multi-cycle integer ALU for the bytecode datapath.
// Single-cycle ops finish straight from IDLE. IMUL and IDIV/IREM work on
// operand magnitudes for WIDTH iterations, then FIX applies the signs.
// Optional macro SEQ_ALU_FAST_MUL_EN: IMUL uses a combinational signed
// multiplier and completes in one cycle; results are identical.
module seq_alu #(
   parameter int WIDTH = 32
) (
   input  logic     clk,
   input  logic     rst_n,
   seq_alu_if.slave bus
);
   localparam int SHW = $clog2(WIDTH);
   localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

   localparam logic [3:0] OP_IADD  = 4'b0000;
   localparam logic [3:0] OP_ISUB  = 4'b0001;
   localparam logic [3:0] OP_IMUL  = 4'b0010;
   localparam logic [3:0] OP_IDIV  = 4'b0011;
   localparam logic [3:0] OP_IREM  = 4'b0100;
   localparam logic [3:0] OP_INEG  = 4'b0101;
   localparam logic [3:0] OP_IOR   = 4'b1000;
   localparam logic [3:0] OP_IXOR  = 4'b1001;
   localparam logic [3:0] OP_ISHL  = 4'b1100;
   localparam logic [3:0] OP_ISHR  = 4'b1101;
   localparam logic [3:0] OP_IUSHR = 4'b1110;
   localparam logic [3:0] OP_IAND  = 4'b1111;

   typedef enum logic [2:0] {ST_IDLE, ST_MUL, ST_DIV, ST_FIX, ST_DONE} state_t;

   state_t               state, next_state;
   logic [3:0]           op_q;
   logic                 neg_a_q, neg_b_q;
   logic [2*WIDTH-1:0]   acc_q;
   logic [WIDTH-1:0]     divisor_q;
   logic [SHW-1:0]       cnt_q;
   logic [WIDTH-1:0]     lo_q, hi_q;
   logic                 dz_q, err_q;

   logic [WIDTH-1:0]     mag_a, mag_b;
   logic [SHW-1:0]       sh;
   logic [WIDTH-1:0]     fast_lo, fast_hi;
   logic                 fast_dz, fast_err, start_mul, start_div;
   logic [WIDTH:0]       mul_sum, div_shift, div_diff;
   logic [2*WIDTH-1:0]   prod_fix;
   logic [WIDTH-1:0]     quo_fix, rem_fix, fix_lo, fix_hi;
`ifdef SEQ_ALU_FAST_MUL_EN
   logic [2*WIDTH-1:0]   fast_prod;
`endif

   // Decode the incoming opcode: compute single-cycle results and flags, and
   // decide whether the iterative multiply or divide path is needed.
   always_comb begin
      fast_lo   = '0;
      fast_hi   = '0;
      fast_dz   = 1'b0;
      fast_err  = 1'b0;
      start_mul = 1'b0;
      start_div = 1'b0;
      mag_a     = bus.operand_a[WIDTH-1] ? -bus.operand_a : bus.operand_a;
      mag_b     = bus.operand_b[WIDTH-1] ? -bus.operand_b : bus.operand_b;
      sh        = bus.operand_b[SHW-1:0];
`ifdef SEQ_ALU_FAST_MUL_EN
      fast_prod = $signed({{WIDTH{bus.operand_a[WIDTH-1]}}, bus.operand_a}) *
                  $signed({{WIDTH{bus.operand_b[WIDTH-1]}}, bus.operand_b});
`endif
      case (bus.op_select)
         OP_IADD:  fast_lo = bus.operand_a + bus.operand_b;
         OP_ISUB:  fast_lo = bus.operand_a - bus.operand_b;
         OP_INEG:  fast_lo = ~bus.operand_a;
         OP_IOR:   fast_lo = bus.operand_a | bus.operand_b;
         OP_IXOR:  fast_lo = bus.operand_a ^ bus.operand_b;
         OP_IAND:  fast_lo = bus.operand_a & bus.operand_b;
         OP_ISHL:  fast_lo = bus.operand_a << sh;
         OP_ISHR:  fast_lo = $unsigned($signed(bus.operand_a) >>> sh);
         OP_IUSHR: fast_lo = bus.operand_a >> sh;
         OP_IMUL: begin
`ifdef SEQ_ALU_FAST_MUL_EN
            fast_lo = fast_prod[WIDTH-1:0];
            fast_hi = fast_prod[2*WIDTH-1:WIDTH];
`else
            start_mul = 1'b1;
`endif
         end
         OP_IDIV, OP_IREM: begin
            if (bus.operand_b == '0) fast_dz = 1'b1;
            else                     start_div = 1'b1;
         end
         default:  fast_err = 1'b1;
      endcase
   end

   // One shift-add / restoring-division step on the magnitudes, plus the
   // sign correction that FIX writes to the result registers.
   always_comb begin
      mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                  {1'b0, (acc_q[0] ? divisor_q : {WIDTH{1'b0}})};
      div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
      div_diff  = div_shift - {1'b0, divisor_q};
      prod_fix  = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
      quo_fix   = (neg_a_q ^ neg_b_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
      rem_fix   = neg_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
      fix_lo    = rem_fix;
      fix_hi    = quo_fix;
      if (op_q == OP_IMUL) begin
         fix_lo = prod_fix[WIDTH-1:0];
         fix_hi = prod_fix[2*WIDTH-1:WIDTH];
      end else if (op_q == OP_IDIV) begin
         fix_lo = quo_fix;
         fix_hi = rem_fix;
      end
   end

   // Next-state logic: accept only in IDLE, iterate WIDTH times, fix signs,
   // then hold the result until the consumer takes it.
   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE: begin
            if (bus.in_valid) begin
               if (start_mul)      next_state = ST_MUL;
               else if (start_div) next_state = ST_DIV;
               else                next_state = ST_DONE;
            end
         end
         ST_MUL, ST_DIV: if (cnt_q == CNT_LAST) next_state = ST_FIX;
         ST_FIX:  next_state = ST_DONE;
         ST_DONE: if (bus.out_ready) next_state = ST_IDLE;
         default: next_state = ST_IDLE;
      endcase
   end

   // State register; reset drops any in-flight operation.
   always_ff @(posedge clk) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= next_state;
   end

   // Datapath registers: capture operands on accept, iterate, write results.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         op_q      <= '0;
         neg_a_q   <= 1'b0;
         neg_b_q   <= 1'b0;
         acc_q     <= '0;
         divisor_q <= '0;
         cnt_q     <= '0;
         lo_q      <= '0;
         hi_q      <= '0;
         dz_q      <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.in_valid) begin
                  op_q      <= bus.op_select;
                  neg_a_q   <= bus.operand_a[WIDTH-1];
                  neg_b_q   <= bus.operand_b[WIDTH-1];
                  acc_q     <= {{WIDTH{1'b0}}, mag_a};
                  divisor_q <= mag_b;
                  cnt_q     <= '0;
                  lo_q      <= fast_lo;
                  hi_q      <= fast_hi;
                  dz_q      <= fast_dz;
                  err_q     <= fast_err;
               end
            end
            ST_MUL: begin
               acc_q <= {mul_sum, acc_q[WIDTH-1:1]};
               cnt_q <= cnt_q + 1'b1;
            end
            ST_DIV: begin
               if (div_diff[WIDTH])
                  acc_q <= {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
               else
                  acc_q <= {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
               cnt_q <= cnt_q + 1'b1;
            end
            ST_FIX: begin
               lo_q <= fix_lo;
               hi_q <= fix_hi;
            end
            default: ;
         endcase
      end
   end

   assign bus.in_ready  = (state == ST_IDLE);
   assign bus.out_valid = (state == ST_DONE);
   assign bus.result_lo = lo_q;
   assign bus.result_hi = hi_q;
   assign bus.div_zero  = dz_q;
   assign bus.op_err    = err_q;
endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (WIDTH=32): directed corner cases plus
// random operations, checked every cycle against a behavioural model.
module tb_seq_alu;
   localparam int WIDTH = 32;
`ifdef SEQ_ALU_FAST_MUL_EN
   localparam int MUL_LAT = 1;
`else
   localparam int MUL_LAT = WIDTH + 2;
`endif

   typedef struct {
      logic [31:0] lo;
      logic [31:0] hi;
      logic        dz;
      logic        err;
      int          lat;
      int          acc;
      bit          seen;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic rst_at_edge = 1'b0;
   logic hold = 1'b0;
   int   cycle = 0;
   int   n_compared = 0;
   int   n_mismatched = 0;
   exp_t exp_q[$];

   seq_alu_if #(.WIDTH(WIDTH)) bus ();

   seq_alu #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   // Cycle counter and the reset level each rising edge actually saw.
   always @(posedge clk) begin
      cycle++;
      rst_at_edge = rst_n;
   end

   // Consumer: random back-pressure unless a hold is requested.
   initial begin
      bus.out_ready = 1'b0;
      forever begin
         @(negedge clk);
         bus.out_ready = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
      end
   end

   // Expected outcome of one operation, from the arithmetic rules alone.
   function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      exp_t   e;
      longint sa, sb, p, q, r;
      int     sh;
      e = '{lo: 0, hi: 0, dz: 0, err: 0, lat: 1, acc: 0, seen: 0};
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      sh = int'(b[4:0]);
      case (op)
         4'h0: e.lo = a + b;
         4'h1: e.lo = a - b;
         4'h2: begin
            p = sa * sb;
            e.lo = p[31:0];
            e.hi = p[63:32];
            e.lat = MUL_LAT;
         end
         4'h3, 4'h4: begin
            if (b == 32'd0) e.dz = 1'b1;
            else begin
               q = sa / sb;
               r = sa % sb;
               e.lo = (op == 4'h3) ? q[31:0] : r[31:0];
               e.hi = (op == 4'h3) ? r[31:0] : q[31:0];
               e.lat = WIDTH + 2;
            end
         end
         4'h5: e.lo = ~a;
         4'h8: e.lo = a | b;
         4'h9: e.lo = a ^ b;
         4'hC: e.lo = a << sh;
         4'hD: e.lo = $unsigned($signed(a) >>> sh);
         4'hE: e.lo = a >> sh;
         4'hF: e.lo = a & b;
         default: e.err = 1'b1;
      endcase
      return e;
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      n_compared++;
      if (actual !== expected) begin
         n_mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cycle);
      end
   endtask

   task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      exp_t e;
      int   waited = 0;
      @(negedge clk);
      while (!bus.in_ready && waited < 300) begin
         @(negedge clk);
         waited++;
      end
      checkOutput("in_ready_wait", bus.in_ready, 1);
      if (!bus.in_ready) return;
      bus.in_valid  = 1'b1;
      bus.op_select = op;
      bus.operand_a = a;
      bus.operand_b = b;
      @(posedge clk);
      #1;
      e = model(op, a, b);
      e.acc = cycle;
      exp_q.push_back(e);
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   task automatic run_directed(input string name, input logic [3:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] lo, input logic [31:0] hi,
                               input logic dz, input logic err, input int lat);
      exp_t e;
      e = model(op, a, b);
      checkOutput({name, "_model_lo"}, e.lo, lo);
      checkOutput({name, "_model_hi"}, e.hi, hi);
      checkOutput({name, "_model_dz"}, e.dz, dz);
      checkOutput({name, "_model_err"}, e.err, err);
      checkOutput({name, "_model_lat"}, e.lat, lat);
      applyStimulus(op, a, b);
   endtask

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 5))
         0:       return 32'h0000_0000;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'($urandom_range(0, 40));
         default: return $urandom;
      endcase
   endfunction

   // Compare process: every cycle, DUT outputs versus the oldest outstanding op.
   initial begin
      int elapsed;
      forever begin
         @(negedge clk);
         #1;
         if (!rst_at_edge) begin
            exp_q.delete();
            checkOutput("rst_out_valid", bus.out_valid, 0);
            checkOutput("rst_in_ready", bus.in_ready, 1);
            checkOutput("rst_lo", bus.result_lo, 0);
            checkOutput("rst_hi", bus.result_hi, 0);
            checkOutput("rst_dz", bus.div_zero, 0);
            checkOutput("rst_err", bus.op_err, 0);
         end else begin
            checkOutput("in_ready", bus.in_ready, exp_q.size() == 0);
            if (exp_q.size() == 0) begin
               checkOutput("idle_out_valid", bus.out_valid, 0);
            end else begin
               elapsed = cycle - exp_q[0].acc + 1;
               if (bus.out_valid) begin
                  if (!exp_q[0].seen) begin
                     checkOutput("latency", elapsed, exp_q[0].lat);
                     exp_q[0].seen = 1'b1;
                  end
                  checkOutput("result_lo", bus.result_lo, exp_q[0].lo);
                  checkOutput("result_hi", bus.result_hi, exp_q[0].hi);
                  checkOutput("div_zero", bus.div_zero, exp_q[0].dz);
                  checkOutput("op_err", bus.op_err, exp_q[0].err);
                  if (bus.out_ready) void'(exp_q.pop_front());
               end else if (!exp_q[0].seen && elapsed >= exp_q[0].lat) begin
                  checkOutput("out_valid_due", bus.out_valid, 1);
                  exp_q[0].seen = 1'b1;
               end
            end
         end
      end
   end

   // Watchdog so the run always ends.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Main sequence.
   initial begin
      int waited;
      bus.in_valid  = 1'b0;
      bus.op_select = '0;
      bus.operand_a = '0;
      bus.operand_b = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      $display("[TB] reset during IDIV");
      applyStimulus(4'h3, 32'd1000, 32'd7);
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      $display("[TB] directed vectors");
      run_directed("iadd", 4'h0, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 32'h0, 0, 0, 1);
      run_directed("imul", 4'h2, 32'hFFFF_FFFD, 32'h7, 32'hFFFF_FFEB, 32'hFFFF_FFFF, 0, 0, MUL_LAT);
      run_directed("idiv", 4'h3, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 0, 0, 34);
      run_directed("irem", 4'h4, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, 0, 34);
      run_directed("idiv_min", 4'h3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0, 0, 0, 34);
      run_directed("idiv_zero", 4'h3, 32'h5, 32'h0, 32'h0, 32'h0, 1, 0, 1);
      run_directed("ishr", 4'hD, 32'h8000_0000, 32'd33, 32'hC000_0000, 32'h0, 0, 0, 1);
      run_directed("iushr", 4'hE, 32'h8000_0000, 32'd33, 32'h4000_0000, 32'h0, 0, 0, 1);
      run_directed("ishl", 4'hC, 32'h1, 32'd33, 32'h0000_0002, 32'h0, 0, 0, 1);

      $display("[TB] hold result with back-pressure");
      hold = 1'b1;
      run_directed("ixor", 4'h9, 32'hF0F0_F0F0, 32'hFFFF_0000, 32'h0F0F_F0F0, 32'h0, 0, 0, 1);
      repeat (5) begin
         bus.in_valid  = 1'b1;
         bus.op_select = 4'h1;
         bus.operand_a = $urandom;
         bus.operand_b = $urandom;
         @(negedge clk);
      end
      bus.in_valid = 1'b0;
      hold = 1'b0;

      run_directed("illegal", 4'h6, 32'h1234_5678, 32'h9, 32'h0, 32'h0, 0, 1, 1);

      $display("[TB] random operations");
      for (int i = 0; i < 80; i++) begin
         applyStimulus(4'($urandom_range(0, 15)), pick_operand(), pick_operand());
      end

      waited = 0;
      while (exp_q.size() != 0 && waited < 300) begin
         @(negedge clk);
         waited++;
      end
      checkOutput("drain_pending", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end
endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, multi-cycle integer ALU for the bytecode execution datapath; successor to the combinational 16-bit-limited ALU.
- Full-width signed multiply (2*WIDTH product on hi:lo) and signed divide/remainder with Java semantics, computed iteratively.
- Adds a valid/ready handshake, a divide-by-zero flag for ArithmeticException, and an illegal-opcode flag.
- Sits between operand-stack read and stack write-back.

Parameters:
- WIDTH, 32, operand/result width; power of two, >= 8.
- SHW, $clog2(WIDTH), shift-amount bits used from operand_b (derived, not overridden).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  operation request.
- in_ready  out  1  ALU can accept; high only in IDLE.
- op_select  in  4  opcode: IADD 0000, ISUB 0001, IMUL 0010, IDIV 0011, IREM 0100, INEG 0101, IOR 1000, IXOR 1001, ISHL 1100, ISHR 1101, IUSHR 1110, IAND 1111.
- operand_a  in  WIDTH  first operand (dividend, shifted value).
- operand_b  in  WIDTH  second operand (divisor, shift amount).
- out_valid  out  1  result available; held until out_ready.
- out_ready  in  1  consumer takes result.
- result_lo  out  WIDTH  primary result.
- result_hi  out  WIDTH  secondary result.
- div_zero  out  1  IDIV/IREM with operand_b == 0; valid with out_valid.
- op_err  out  1  undefined opcode; valid with out_valid.

Behaviour:
- Interface: single clock clk; reset rst_n is synchronous and active-low.
- Reset: rst_n low at a rising edge -> state IDLE; out_valid, result_lo, result_hi, div_zero, op_err = 0; in_ready = 1 on the next cycle. Reset aborts any in-flight MUL/DIV with no output.
- Operands and opcode are registered on accept (in_valid && in_ready). Inputs are ignored outside IDLE.
- States and transitions:
  - IDLE -> DONE: single-cycle op, div-by-zero, or illegal opcode.
  - IDLE -> MUL: IMUL.
  - IDLE -> DIV: IDIV/IREM with divisor != 0.
  - MUL/DIV -> FIX: after exactly WIDTH iteration cycles (counter 0..WIDTH-1).
  - FIX -> DONE.
  - DONE -> IDLE when out_ready.
- Latency, in rising edges from accept edge to out_valid high:
  - Single-cycle ops: 1.
  - IMUL, IDIV, IREM: WIDTH+2.
- DONE: out_valid = 1; outputs stable until out_ready. Same-cycle out_ready is honoured, giving in_ready the following cycle.
- Arithmetic, all mod 2^WIDTH unless stated:
  - IADD/ISUB: a+b, a-b; hi = 0.
  - IMUL: magnitudes multiplied by shift-add, sign applied in FIX; {hi,lo} = signed 2*WIDTH product.
  - IDIV: lo = quotient truncated toward zero; hi = remainder.
  - IREM: lo = remainder, sign follows dividend; hi = quotient.
  - Both IDIV and IREM use restoring division on magnitudes, with signs fixed in FIX.
  - MIN / -1: quotient = MIN, remainder = 0, no flag.
  - Divisor 0: lo = hi = 0, div_zero = 1, latency 1.
  - INEG: ~a (bitwise; opcode semantics unchanged from previous ALU); hi = 0.
  - IAND/IOR/IXOR: bitwise; hi = 0.
  - ISHL: a << (b[SHW-1:0]).
  - ISHR: arithmetic right shift.
  - IUSHR: logical right shift.
  - All shifts: hi = 0.
  - Undefined opcode (0110, 0111, 1010, 1011): lo = hi = 0, op_err = 1, latency 1.
- div_zero and op_err are cleared on every accept.

Optional Feature:
- Macro: SEQ_ALU_FAST_MUL_EN.
- Defined: IMUL uses a combinational WIDTH x WIDTH signed multiplier; IMUL takes the IDLE -> DONE path with latency 1; MUL state unused.
- Undefined: IMUL uses the iterative path with latency WIDTH+2.
- Result values are identical in both builds.

Test Plan:
- WIDTH=32; rst_n low 2 cycles mid-IDIV, then released -> out_valid stays 0, in_ready=1; next op IADD 0x7FFFFFFF+1 -> lo=0x80000000, hi=0, out_valid 1 edge after accept.
- IMUL a=-3 (0xFFFFFFFD), b=7 -> lo=0xFFFFFFEB, hi=0xFFFFFFFF, out_valid at accept+34 (accept+1 with SEQ_ALU_FAST_MUL_EN).
- IDIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. IREM same operands -> lo=0xFFFFFFFF, hi=0xFFFFFFFD.
- IDIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0, div_zero=0. IDIV a=5, b=0 -> lo=0, div_zero=1, latency 1.
- a=0x80000000, b=33: ISHR -> 0xC0000000; IUSHR -> 0x40000000; ISHL with a=1 -> 0x00000002.
- Hold out_ready=0 for 5 cycles after an IXOR (0xF0F0F0F0 ^ 0xFFFF0000 = 0x0F0FF0F0) -> outputs stable, in_ready=0, new in_valid ignored. Opcode 0110 -> op_err=1, lo=0.
